// File: rtl/display_seg7.sv
// display_seg7: registered 7-segment glyph decoder for the keypad-lock display.
// Converts a 5-bit digit code into segment drives {g,f,e,d,c,b,a} for the digit
// currently selected by the parent's scan logic. Codes 0-9 show a decimal glyph;
// every other code (including BLANK_CODE) blanks the digit.
// Optional build macro: DISPLAY_ACTIVE_HIGH_EN inverts all segment drives for
// common-cathode displays. Without it the drives are active-low (common-anode).
module display_seg7 #(
   parameter logic [4:0] BLANK_CODE = 5'd10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] num,
   output logic [6:0] led
);

   // Active-low glyphs; the reset glyph is '0' because the lock shows 0000 on reset.
   localparam logic [6:0] GLYPH_ZERO  = 7'h40;
   localparam logic [6:0] GLYPH_BLANK = 7'h7F;

   logic [6:0] glyph_low;
   logic [6:0] glyph_drive;
   logic [6:0] reset_drive;

   // Decode the digit code to an active-low glyph; anything outside 0-9 blanks.
   always_comb begin
      glyph_low = GLYPH_BLANK;
      if (num == BLANK_CODE || num > 5'd9) begin
         glyph_low = GLYPH_BLANK;
      end else begin
         case (num)
            5'd0:    glyph_low = 7'h40;
            5'd1:    glyph_low = 7'h79;
            5'd2:    glyph_low = 7'h24;
            5'd3:    glyph_low = 7'h30;
            5'd4:    glyph_low = 7'h19;
            5'd5:    glyph_low = 7'h12;
            5'd6:    glyph_low = 7'h02;
            5'd7:    glyph_low = 7'h78;
            5'd8:    glyph_low = 7'h00;
            5'd9:    glyph_low = 7'h10;
            default: glyph_low = GLYPH_BLANK;
         endcase
      end
   end

`ifdef DISPLAY_ACTIVE_HIGH_EN
   // Common-cathode panel: segments light on a high drive, so invert everything.
   assign glyph_drive = ~glyph_low;
   assign reset_drive = ~GLYPH_ZERO;
`else
   // Common-anode panel: drive the active-low glyph as tabulated.
   assign glyph_drive = glyph_low;
   assign reset_drive = GLYPH_ZERO;
`endif

   // Output register: shows zero while reset is held, otherwise the decoded glyph.
   always_ff @(posedge clk) begin
      if (rst) begin
         led <= reset_drive;
      end else begin
         led <= glyph_drive;
      end
   end

endmodule

// File: tb/tb_display_seg7.sv
// tb_display_seg7: directed self-checking bench for display_seg7.
// Expected glyphs are hand-written constants; polarity follows DISPLAY_ACTIVE_HIGH_EN.
module tb_display_seg7;

   logic       clk;
   logic       rst;
   logic [4:0] num;
   logic [6:0] led;

   int checkCount;
   int failCount;

   display_seg7 dut (
      .clk (clk),
      .rst (rst),
      .num (num),
      .led (led)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Map an active-low table value to the drive polarity of this build.
   function automatic logic [6:0] polar(input logic [6:0] lowValue);
`ifdef DISPLAY_ACTIVE_HIGH_EN
      return ~lowValue;
`else
      return lowValue;
`endif
   endfunction

   // Compare one observed value against its expectation and tally the result.
   task automatic checkOutput(input string tag, input logic [6:0] observed,
                              input logic [6:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: led=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drive inputs on the falling edge, then wait past the next rising edge.
   task automatic applyStimulus(input logic rstValue, input logic [4:0] numValue);
      @(negedge clk);
      rst = rstValue;
      num = numValue;
      @(posedge clk);
      #1;
   endtask

   logic [6:0] digitTable [10];
   logic [4:0] scanNum    [4];
   logic [6:0] scanLed    [4];

   initial begin
      checkCount = 0;
      failCount  = 0;
      rst = 1'b1;
      num = 5'd7;

      digitTable[0] = 7'h40; digitTable[1] = 7'h79; digitTable[2] = 7'h24;
      digitTable[3] = 7'h30; digitTable[4] = 7'h19; digitTable[5] = 7'h12;
      digitTable[6] = 7'h02; digitTable[7] = 7'h78; digitTable[8] = 7'h00;
      digitTable[9] = 7'h10;

      scanNum[0] = 5'd10; scanLed[0] = 7'h7F;
      scanNum[1] = 5'd5;  scanLed[1] = 7'h12;
      scanNum[2] = 5'd10; scanLed[2] = 7'h7F;
      scanNum[3] = 5'd2;  scanLed[3] = 7'h24;

      // Reset held for two edges with a nonzero code shows zero each time.
      applyStimulus(1'b1, 5'd7);
      checkOutput("reset_edge1", led, polar(7'h40));
      applyStimulus(1'b1, 5'd7);
      checkOutput("reset_edge2", led, polar(7'h40));

      // Sweep digits 0-9, one per cycle.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 5'(i));
         checkOutput($sformatf("digit_%0d", i), led, polar(digitTable[i]));
      end

      // Output must not change before the clock edge (no combinational path).
      @(negedge clk);
      num = 5'd1;
      #1;
      checkOutput("no_comb_path", led, polar(7'h10));
      @(posedge clk);
      #1;
      checkOutput("registered_1", led, polar(7'h79));

      // Blanking codes: explicit blank, mid-range, and top of range.
      applyStimulus(1'b0, 5'd10);
      checkOutput("blank_10", led, polar(7'h7F));
      applyStimulus(1'b0, 5'd15);
      checkOutput("blank_15", led, polar(7'h7F));
      applyStimulus(1'b0, 5'd31);
      checkOutput("blank_31", led, polar(7'h7F));

      // Single-cycle reset pulse with steady code 3.
      applyStimulus(1'b0, 5'd3);
      checkOutput("pulse_before", led, polar(7'h30));
      applyStimulus(1'b1, 5'd3);
      checkOutput("pulse_reset", led, polar(7'h40));
      applyStimulus(1'b0, 5'd3);
      checkOutput("pulse_after", led, polar(7'h30));

      // Reset with a blank code still shows zero.
      applyStimulus(1'b1, 5'd31);
      checkOutput("reset_over_blank", led, polar(7'h40));

      // Scan pattern alternating blank and digits.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, scanNum[i]);
         checkOutput($sformatf("scan_%0d", i), led, polar(scanLed[i]));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
